phase_a_iter_seq: RTL and testbench

//  Sequencer that runs the phase_a reduction datapath repeatedly on one operand: the

---
 rtl/phase_a_pkg.sv | 24 ++
 rtl/phase_a_wdog.sv | 48 ++++
 rtl/phase_a_iter_seq.sv | 210 +++++++++++++++++++++
 tb/tb_phase_a_iter_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_a_pkg.sv
// Shared definitions for the phase_a reduction datapath and its pass sequencer:
// sequencer state encoding and the default sizing constants.
package phase_a_pkg;

  // Operand width and digit radix shared with the phase_a datapath.
  localparam int unsigned PA_SIZE    = 3072;
  localparam int unsigned PA_RADIX   = 64;

  // Sequencer defaults: pass-count width, per-pass watchdog limit and counter width.
  localparam int unsigned PA_ITER_W  = 8;
  localparam int unsigned PA_TIMEOUT = 63;
  localparam int unsigned PA_TO_W    = 6;

  // Pass sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4,
    ST_DRAIN  = 3'd5
  } pa_state_e;

endpackage : phase_a_pkg

// File: rtl/phase_a_wdog.sv
// Watchdog for the phase_a pass sequencer. Counts enabled cycles since the last
// clear and flags expiry on the TIMEOUT-th enabled cycle. The count saturates
// there, so expiry stays asserted until the next clear.
module phase_a_wdog
  import phase_a_pkg::*;
#(
  parameter int unsigned TIMEOUT = PA_TIMEOUT,
  parameter int unsigned TO_W    = PA_TO_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // The count is zero in the first enabled cycle. The TIMEOUT-th enabled cycle
  // therefore holds TIMEOUT-1.
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Next count: clear has priority; otherwise count enabled cycles up to the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {TO_W{1'b0}};
    end else if (en_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {TO_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == CNT_LAST);

endmodule : phase_a_wdog

// File: rtl/phase_a_iter_seq.sv
// Pass sequencer for phase_a. It feeds the result of each reduction pass back
// as the next operand, a chosen number of times. It pulses phase_a's
// edge-triggered enable once per pass and holds the operand stable while the
// pass runs. A watchdog catches a pass that never completes. After an error or
// an abort, the DRAIN state soaks up any late en_out, so a stale completion can
// never be credited to a later job.
module phase_a_iter_seq
  import phase_a_pkg::*;
#(
  parameter int unsigned SIZE    = PA_SIZE,
  parameter int unsigned ITER_W  = PA_ITER_W,
  parameter int unsigned TIMEOUT = PA_TIMEOUT,
  parameter int unsigned TO_W    = PA_TO_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE-1:0]   a_in,
  input  logic [ITER_W-1:0] n_iter,
  input  logic              abort,
  output logic              pa_en,
  output logic [SIZE-1:0]   pa_a,
  input  logic [SIZE-1:0]   pa_new_a,
  input  logic              pa_en_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [SIZE-1:0]   result
);

  localparam logic [ITER_W-1:0] ITER_ZERO = {ITER_W{1'b0}};
  localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);

  pa_state_e         state_q;
  pa_state_e         state_d;
  logic [SIZE-1:0]   pa_a_q;
  logic [SIZE-1:0]   pa_a_d;
  logic [SIZE-1:0]   result_q;
  logic [SIZE-1:0]   result_d;
  logic [ITER_W-1:0] remaining_q;
  logic [ITER_W-1:0] remaining_d;

  logic              accept_s;
  logic              capture_s;
  logic              last_pass_s;
  logic              wdog_clr_s;
  logic              wdog_en_s;
  logic              wdog_expired_s;

  // A new job is accepted only from IDLE, and abort always wins over start.
  assign accept_s    = (state_q == ST_IDLE) && start && !abort;
  // A pass result is taken only while waiting for it, and never during an abort.
  assign capture_s   = (state_q == ST_WAIT) && pa_en_out && !abort;
  assign last_pass_s = (remaining_q == ITER_ONE);

  // The watchdog restarts on every state change. It runs only while waiting on
  // phase_a.
  assign wdog_clr_s  = (state_d != state_q);
  assign wdog_en_s   = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

  phase_a_wdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wdog_clr_s),
    .en_i      (wdog_en_s),
    .expired_o (wdog_expired_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. Abort sends any active state to DRAIN. In WAIT, a completion
  // in the same cycle as watchdog expiry counts as a completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (n_iter == ITER_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LAUNCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        if (abort) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_DRAIN;
        end else if (pa_en_out) begin
          if (last_pass_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LAUNCH;
          end
        end else if (wdog_expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pa_en_out || wdog_expired_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs. Abort clears pa_en, done and err in the same cycle it is asserted.
  always_comb begin
    pa_en = 1'b0;
    done  = 1'b0;
    err   = 1'b0;
    busy  = (state_q != ST_IDLE);
    case (state_q)
      ST_LAUNCH: begin
        pa_en = !abort;
      end
      ST_DONE: begin
        done = !abort;
      end
      ST_ERR: begin
        err = !abort;
      end
      default: begin
        pa_en = 1'b0;
        done  = 1'b0;
        err   = 1'b0;
      end
    endcase
  end

  assign pa_a   = pa_a_q;
  assign result = result_q;

  // Operand, pass count and result updates.
  always_comb begin
    pa_a_d      = pa_a_q;
    remaining_d = remaining_q;
    result_d    = result_q;
    if (accept_s) begin
      pa_a_d      = a_in;
      remaining_d = n_iter;
      if (n_iter == ITER_ZERO) begin
        result_d = a_in;
      end else begin
        result_d = result_q;
      end
    end else if (capture_s) begin
      pa_a_d      = pa_new_a;
      remaining_d = remaining_q - ITER_ONE;
      if (last_pass_s) begin
        result_d = pa_new_a;
      end else begin
        result_d = result_q;
      end
    end else begin
      pa_a_d      = pa_a_q;
      remaining_d = remaining_q;
      result_d    = result_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_a_q      <= {SIZE{1'b0}};
      remaining_q <= ITER_ZERO;
      result_q    <= {SIZE{1'b0}};
    end else begin
      pa_a_q      <= pa_a_d;
      remaining_q <= remaining_d;
      result_q    <= result_d;
    end
  end

endmodule : phase_a_iter_seq

// File: tb/tb_phase_a_iter_seq.sv
// Self-checking bench for phase_a_iter_seq. A phase_a stub has fixed latency L
// and computes new_a = a + 1, triggered by a rising edge of its enable. Each
// accepted start pushes its expected result to a scoreboard queue. Every done
// pulse pops an entry and compares it with the result output.
module tb_phase_a_iter_seq;

  localparam int unsigned SIZE    = 32;
  localparam int unsigned ITER_W  = 8;
  localparam int unsigned TIMEOUT = 63;
  localparam int unsigned TO_W    = 6;
  localparam int          L       = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [SIZE-1:0]   a_in = '0;
  logic [ITER_W-1:0] n_iter = '0;
  logic              pa_en;
  logic [SIZE-1:0]   pa_a;
  logic [SIZE-1:0]   pa_new_a;
  logic              pa_en_out;
  logic              busy;
  logic              done;
  logic              err;
  logic [SIZE-1:0]   result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pa_en_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int pe_times[$];
  logic [SIZE-1:0] exp_q[$];

  // phase_a stub state
  logic            stub_mute = 1'b0;
  logic            stub_prev;
  int              stub_cnt;
  logic [SIZE-1:0] stub_a;

  phase_a_iter_seq #(
    .SIZE    (SIZE),
    .ITER_W  (ITER_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_in      (a_in),
    .n_iter    (n_iter),
    .abort     (abort),
    .pa_en     (pa_en),
    .pa_a      (pa_a),
    .pa_new_a  (pa_new_a),
    .pa_en_out (pa_en_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Cycle counter, advanced on each active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Stub phase_a: a rising edge on en latches a; en_out follows L cycles after the pa_en cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_prev <= 1'b0;
      stub_cnt  <= 0;
      stub_a    <= '0;
    end else begin
      stub_prev <= pa_en;
      if (pa_en && !stub_prev) begin
        stub_cnt <= L;
        stub_a   <= pa_a;
      end else if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end
  assign pa_en_out = (stub_cnt == 1) && !stub_mute;
  assign pa_new_a  = stub_a + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Wait on negedges for: 0 done, 1 err, 2 pa_en, 3 not busy.
  task automatic wait_for(input int which, input int budget, input string tag, output int at_cyc);
    bit hit;
    hit = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = done;
        1: hit = err;
        2: hit = pa_en;
        3: hit = !busy;
        default: hit = 1'b1;
      endcase
      if (hit) at_cyc = cyc;
    end
    if (!hit) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Present start for one active edge; optionally push the expected result.
  task automatic do_start(input logic [SIZE-1:0] a, input logic [ITER_W-1:0] n,
                          input bit push, output int s_cyc);
    @(negedge clk);
    s_cyc  = cyc;
    start  = 1'b1;
    a_in   = a;
    n_iter = n;
    if (push) exp_q.push_back(a + n);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Monitor: counts pulses and scores every done against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pa_en) begin
          pa_en_cnt++;
          pe_times.push_back(cyc);
        end
        if (err) err_cnt++;
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) check_eq("done_unexpected", 64'd1, 64'd0);
          else check_eq("scoreboard_result", result, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int s, d, p, p1, p2, e, i, pe0, dc0, ec0;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_pa_en", pa_en, 0);
    check_eq("rst_pa_a", pa_a, 0);
    check_eq("rst_result", result, 0);
    rst_n = 1'b1;

    // 1: three passes of 5 -> 8
    pe0 = pa_en_cnt;
    pe_times.delete();
    do_start(5, 3, 1, s);
    wait_for(0, 300, "t1_done", d);
    check_eq("t1_pa_en_count", pa_en_cnt - pe0, 3);
    check_eq("t1_pe_times", pe_times.size(), 3);
    if (pe_times.size() == 3) begin
      check_eq("t1_gap1_ge21", (pe_times[1] - pe_times[0]) >= 21, 1);
      check_eq("t1_gap2_ge21", (pe_times[2] - pe_times[1]) >= 21, 1);
    end
    check_eq("t1_latency", d - s, 3 * (L + 1) + 1);
    check_eq("t1_result", result, 8);
    @(negedge clk);
    check_eq("t1_busy_after_done", busy, 0);
    check_eq("t1_result_held", result, 8);

    // 2: zero passes returns the operand without launching phase_a
    pe0 = pa_en_cnt;
    do_start(32'hABC, 0, 1, s);
    @(negedge clk);
    check_eq("t2_done", done, 1);
    check_eq("t2_result", result, 32'hABC);
    @(negedge clk);
    check_eq("t2_busy", busy, 0);
    check_eq("t2_no_pa_en", pa_en_cnt - pe0, 0);

    // 3: phase_a never answers -> err, then a full drain
    stub_mute = 1'b1;
    dc0 = done_cnt;
    ec0 = err_cnt;
    do_start(7, 2, 0, s);
    wait_for(2, 10, "t3_pa_en", p);
    wait_for(1, 200, "t3_err", e);
    check_eq("t3_err_latency", e - p, TIMEOUT + 1);
    @(negedge clk);
    check_eq("t3_busy_in_drain", busy, 1);
    wait_for(3, 200, "t3_idle", i);
    check_eq("t3_drain_len", i - e - 1, TIMEOUT);
    check_eq("t3_err_count", err_cnt - ec0, 1);
    check_eq("t3_no_done", done_cnt - dc0, 0);
    check_eq("t3_result_kept", result, 32'hABC);
    stub_mute = 1'b0;

    // 4: abort mid-WAIT; the stub's late en_out ends the drain
    dc0 = done_cnt;
    ec0 = err_cnt;
    pe0 = pa_en_cnt;
    do_start(10, 4, 0, s);
    wait_for(2, 10, "t4_pe1", p1);
    wait_for(2, 50, "t4_pe2", p2);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_for(3, 200, "t4_idle", i);
    check_eq("t4_drain_by_en_out", i - p2, L + 1);
    check_eq("t4_pa_en_count", pa_en_cnt - pe0, 2);

    // 4a: abort during LAUNCH kills the pulse at once; the drain runs to timeout
    do_start(9, 2, 0, s);
    @(negedge clk);
    abort = 1'b1;
    #1 check_eq("t4_abort_kills_pa_en", pa_en, 0);
    @(posedge clk);
    #1 abort = 1'b0;
    wait_for(3, 200, "t4a_idle", i);
    check_eq("t4a_drain_timeout", i - s, TIMEOUT + 2);
    check_eq("t4_no_done", done_cnt - dc0, 0);
    check_eq("t4_no_err", err_cnt - ec0, 0);
    check_eq("t4_result_kept", result, 32'hABC);

    // 4b: fresh job after the aborts
    do_start(1, 1, 1, s);
    wait_for(0, 100, "t4b_done", d);
    check_eq("t4b_result", result, 2);

    // 5: starts while busy, and start+abort in IDLE, are ignored
    pe0 = pa_en_cnt;
    dc0 = done_cnt;
    do_start(3, 2, 1, s);
    for (int k = 0; k < 3; k++) begin
      repeat (7) @(negedge clk);
      start = 1'b1;
      a_in = 99;
      n_iter = 9;
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_for(0, 200, "t5_done", d);
    check_eq("t5_result", result, 5);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    a_in = 50;
    n_iter = 1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_eq("t5_start_abort_idle", busy, 0);
    repeat (30) @(negedge clk);
    check_eq("t5_pa_en_count", pa_en_cnt - pe0, 2);
    check_eq("t5_done_count", done_cnt - dc0, 1);

    // 6: asynchronous reset mid-WAIT, then a fresh job
    do_start(20, 3, 1, s);
    wait_for(2, 10, "t6_pa_en", p);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_pa_en", pa_en, 0);
    check_eq("t6_rst_done", done, 0);
    check_eq("t6_rst_err", err, 0);
    check_eq("t6_rst_pa_a", pa_a, 0);
    check_eq("t6_rst_result", result, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_start(100, 2, 1, s);
    wait_for(0, 100, "t6_done", d);
    check_eq("t6_result", result, 102);

    repeat (2) @(negedge clk);
    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_phase_a_iter_seq
